// File: rtl/feature_loader.sv
// Feature-map loader: reads a feature map from memory in bursts and streams
// 4-pixel x 8-channel words to one or two feature buffers. Optional macro: FEATURE_LOADER_PERF_CNT_EN.
module feature_loader #(
  parameter int FEATURE_WIDTH  = 16,
  parameter int MEM_DATA_WIDTH = 32 * FEATURE_WIDTH,
  parameter int ADDR_WIDTH     = 32,
  parameter int BURST_LEN      = 16
) (
  input  logic                      system_clk,
  input  logic                      rst,
  input  logic                      load_begin,
  output logic                      load_finish,
  output logic                      busy,
  input  logic [9:0]                row_size,
  input  logic [9:0]                col_size,
  input  logic                      feature_double_patch,
  input  logic [ADDR_WIDTH-1:0]     base_addr_1,
  input  logic [ADDR_WIDTH-1:0]     base_addr_2,
  output logic                      mem_rd_req_valid,
  input  logic                      mem_rd_req_ready,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
  output logic [6:0]                mem_rd_len,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  input  logic                      mem_rd_data_valid,
  output logic                      mem_rd_data_ready,
  output logic [MEM_DATA_WIDTH-1:0] feature_data,
  output logic                      feature_buffer_1_valid,
  output logic                      feature_buffer_2_valid,
  input  logic                      feature_buffer_1_ready,
  input  logic                      feature_buffer_2_ready,
  output logic [31:0]               stall_cycles
);

  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(MEM_DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, REQ, DATA, FINISH} state_t;

  state_t                state;
  logic [17:0]           rem_1;
  logic [17:0]           rem_2;
  logic [ADDR_WIDTH-1:0] ptr_1;
  logic [ADDR_WIDTH-1:0] ptr_2;
  logic                  double_patch;
  logic                  cur_is_2;
  logic [6:0]            beat_cnt;

  logic [19:0]           pixel_count;
  logic [17:0]           total_words;
  logic                  target_ready;
  logic [17:0]           cur_rem;
  logic [6:0]            burst_len;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic                  beat;

  // A partial last word is still fetched whole, hence the round-up.
  assign pixel_count  = 20'(row_size) * 20'(col_size);
  assign total_words  = 18'((pixel_count + 20'd3) >> 2);
  assign target_ready = cur_is_2 ? feature_buffer_2_ready : feature_buffer_1_ready;
  assign cur_rem      = cur_is_2 ? rem_2 : rem_1;
  assign burst_len    = (cur_rem >= 18'(BURST_LEN)) ? 7'(BURST_LEN) : cur_rem[6:0];
  assign burst_bytes  = ADDR_WIDTH'(mem_rd_len) * WORD_BYTES;
  assign beat         = mem_rd_data_valid && mem_rd_data_ready;

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      rem_1                  <= '0;
      rem_2                  <= '0;
      ptr_1                  <= '0;
      ptr_2                  <= '0;
      double_patch           <= 1'b0;
      cur_is_2               <= 1'b0;
      beat_cnt               <= '0;
      load_finish            <= 1'b0;
      busy                   <= 1'b0;
      mem_rd_req_valid       <= 1'b0;
      mem_rd_addr            <= '0;
      mem_rd_len             <= '0;
      mem_rd_data_ready      <= 1'b0;
      feature_data           <= '0;
      feature_buffer_1_valid <= 1'b0;
      feature_buffer_2_valid <= 1'b0;
    end else begin
      feature_buffer_1_valid <= 1'b0;
      feature_buffer_2_valid <= 1'b0;
      load_finish            <= 1'b0;
      case (state)
        IDLE: begin
          if (load_begin) begin
            double_patch <= feature_double_patch;
            rem_1        <= total_words;
            rem_2        <= total_words;
            ptr_1        <= base_addr_1;
            ptr_2        <= base_addr_2;
            cur_is_2     <= 1'b0;
            busy         <= 1'b1;
            state        <= (total_words == '0) ? FINISH : REQ;
          end
        end
        REQ: begin
          // Once raised, the request is held even if the buffer ready drops.
          if (!mem_rd_req_valid) begin
            if (target_ready) begin
              mem_rd_req_valid <= 1'b1;
              mem_rd_addr      <= cur_is_2 ? ptr_2 : ptr_1;
              mem_rd_len       <= burst_len;
            end
          end else if (mem_rd_req_ready) begin
            mem_rd_req_valid <= 1'b0;
            if (cur_is_2) begin
              ptr_2 <= ptr_2 + burst_bytes;
              rem_2 <= rem_2 - 18'(mem_rd_len);
            end else begin
              ptr_1 <= ptr_1 + burst_bytes;
              rem_1 <= rem_1 - 18'(mem_rd_len);
            end
            beat_cnt          <= mem_rd_len;
            mem_rd_data_ready <= 1'b1;
            state             <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            feature_data           <= mem_rd_data;
            feature_buffer_1_valid <= !cur_is_2;
            feature_buffer_2_valid <= cur_is_2;
            beat_cnt               <= beat_cnt - 7'd1;
            if (beat_cnt == 7'd1) begin
              mem_rd_data_ready <= 1'b0;
              // Patches have equal word counts, so patch 1's counter decides completion.
              if (double_patch && !cur_is_2) begin
                cur_is_2 <= 1'b1;
                state    <= REQ;
              end else begin
                cur_is_2 <= 1'b0;
                state    <= (rem_1 != '0) ? REQ : FINISH;
              end
            end
          end
        end
        FINISH: begin
          load_finish <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FEATURE_LOADER_PERF_CNT_EN
  logic stall;

  // A stall is a REQ cycle lost to the buffer or the memory port, not to our own request latency.
  assign stall = (state == REQ) && !(mem_rd_req_valid && mem_rd_req_ready) &&
                 (!target_ready || !mem_rd_req_ready);

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == IDLE && load_begin) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_feature_loader.sv
// Scoreboard bench for feature_loader: directed loads, a reactive memory model,
// and a negedge monitor that checks requests, feature words and load_finish.
module tb_feature_loader;
  localparam int FW  = 16;
  localparam int MDW = 512;
  localparam int AW  = 32;
  localparam int BL  = 16;

  logic           system_clk = 1'b0;
  logic           rst = 1'b1;
  logic           load_begin = 1'b0;
  logic           load_finish, busy;
  logic [9:0]     row_size = '0, col_size = '0;
  logic           feature_double_patch = 1'b0;
  logic [AW-1:0]  base_addr_1 = '0, base_addr_2 = '0;
  logic           mem_rd_req_valid;
  logic           mem_rd_req_ready = 1'b0;
  logic [AW-1:0]  mem_rd_addr;
  logic [6:0]     mem_rd_len;
  logic [MDW-1:0] mem_rd_data = '0;
  logic           mem_rd_data_valid = 1'b0;
  logic           mem_rd_data_ready;
  logic [MDW-1:0] feature_data;
  logic           feature_buffer_1_valid, feature_buffer_2_valid;
  logic           feature_buffer_1_ready = 1'b1, feature_buffer_2_ready = 1'b1;
  logic [31:0]    stall_cycles;

  always #5 system_clk = ~system_clk;

  feature_loader #(.FEATURE_WIDTH(FW), .MEM_DATA_WIDTH(MDW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .system_clk(system_clk), .rst(rst), .load_begin(load_begin), .load_finish(load_finish),
    .busy(busy), .row_size(row_size), .col_size(col_size),
    .feature_double_patch(feature_double_patch), .base_addr_1(base_addr_1),
    .base_addr_2(base_addr_2), .mem_rd_req_valid(mem_rd_req_valid),
    .mem_rd_req_ready(mem_rd_req_ready), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
    .mem_rd_data_ready(mem_rd_data_ready), .feature_data(feature_data),
    .feature_buffer_1_valid(feature_buffer_1_valid), .feature_buffer_2_valid(feature_buffer_2_valid),
    .feature_buffer_1_ready(feature_buffer_1_ready), .feature_buffer_2_ready(feature_buffer_2_ready),
    .stall_cycles(stall_cycles)
  );

  typedef struct {logic [31:0] addr; logic [6:0] len;} req_t;

  int total = 0;
  int bad   = 0;
  req_t        exp_req[$];
  logic [31:0] exp_f1[$];
  logic [31:0] exp_f2[$];
  bit          exp_fin[$];
  logic [31:0] beat_q[$];
  bit mem_gap = 0, req_gap = 0, junk_en = 0;
  int n_f1 = 0;

  function automatic logic [MDW-1:0] word_of(input logic [31:0] a);
    return {16{a}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [MDW-1:0] act, input logic [MDW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  task automatic push_req(input logic [31:0] a, input logic [6:0] l);
    req_t r;
    r.addr = a;
    r.len  = l;
    exp_req.push_back(r);
  endtask

  task automatic push_words(input logic [31:0] base, input int n, input int patch);
    for (int i = 0; i < n; i++) begin
      if (patch == 1) exp_f1.push_back(base + 32'(i) * 32'd64);
      else            exp_f2.push_back(base + 32'(i) * 32'd64);
    end
  endtask

  // Memory model: drives inputs just after each rising edge.
  always @(posedge system_clk) begin
    #1;
    if (rst) begin
      mem_rd_req_ready  = 1'b0;
      mem_rd_data_valid = 1'b0;
      beat_q.delete();
    end else begin
      mem_rd_req_ready = req_gap ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_rd_req_valid && mem_rd_req_ready)
        for (int i = 0; i < int'(mem_rd_len); i++) beat_q.push_back(mem_rd_addr + 32'(i) * 32'd64);
      if (mem_rd_data_ready && beat_q.size() > 0 && !(mem_gap && $urandom_range(0, 3) == 0)) begin
        mem_rd_data_valid = 1'b1;
        mem_rd_data       = word_of(beat_q.pop_front());
      end else if (!mem_rd_data_ready && junk_en) begin
        mem_rd_data_valid = 1'b1;
        mem_rd_data       = word_of(32'hBAD0_BAD0);
      end else begin
        mem_rd_data_valid = 1'b0;
      end
    end
  end

  // Monitor: samples on the falling edge and pops the scoreboard.
  bit             prev_pend = 0, prev_beat = 0, prev_fv = 0;
  logic [31:0]    prev_addr = '0;
  logic [6:0]     prev_len = '0;
  logic [MDW-1:0] last_data = '0;
  always @(negedge system_clk) begin
    if (rst) begin
      prev_pend = 0; prev_beat = 0; prev_fv = 0; last_data = '0;
    end else begin
      if (prev_pend) begin
        check("req_hold_valid", mem_rd_req_valid, 1);
        check("req_hold_addr", mem_rd_addr, prev_addr);
        check("req_hold_len", mem_rd_len, prev_len);
      end
      if (mem_rd_req_valid && mem_rd_req_ready) begin
        if (exp_req.size() == 0) fail("req_unexpected", mem_rd_addr);
        else begin
          req_t r;
          r = exp_req.pop_front();
          check("req_addr", mem_rd_addr, r.addr);
          check("req_len", mem_rd_len, r.len);
        end
      end
      if (feature_buffer_1_valid || feature_buffer_2_valid || prev_beat)
        check("valid_latency", feature_buffer_1_valid | feature_buffer_2_valid, prev_beat);
      if (feature_buffer_1_valid && feature_buffer_2_valid) fail("both_valids", 2'b11);
      if (feature_buffer_1_valid) begin
        n_f1++;
        if (exp_f1.size() == 0) fail("f1_unexpected", feature_data[63:0]);
        else check_data("f1_data", feature_data, word_of(exp_f1.pop_front()));
      end else if (feature_buffer_2_valid) begin
        if (exp_f2.size() == 0) fail("f2_unexpected", feature_data[63:0]);
        else check_data("f2_data", feature_data, word_of(exp_f2.pop_front()));
      end else begin
        check_data("data_hold", feature_data, last_data);
      end
      if (feature_buffer_1_valid || feature_buffer_2_valid) last_data = feature_data;
      if (load_finish) begin
        if (exp_fin.size() == 0) fail("finish_unexpected", 1);
        else begin
          check("finish_after_valid", prev_fv, exp_fin.pop_front());
          check("finish_f1_left", exp_f1.size(), 0);
          check("finish_f2_left", exp_f2.size(), 0);
        end
      end
      prev_fv   = feature_buffer_1_valid | feature_buffer_2_valid;
      prev_beat = mem_rd_data_valid && mem_rd_data_ready;
      prev_pend = mem_rd_req_valid && !mem_rd_req_ready;
      prev_addr = mem_rd_addr;
      prev_len  = mem_rd_len;
    end
  end

  task automatic start(input logic [9:0] r, input logic [9:0] c, input logic d,
                       input logic [31:0] a1, input logic [31:0] a2);
    @(posedge system_clk); #1;
    row_size = r; col_size = c; feature_double_patch = d;
    base_addr_1 = a1; base_addr_2 = a2; load_begin = 1'b1;
    @(posedge system_clk); #1;
    load_begin = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_fin.size() != 0 || busy) && n < budget) begin
      @(negedge system_clk);
      n++;
    end
    check({name, "_in_time"}, n < budget, 1);
    check({name, "_req_left"}, exp_req.size(), 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    int hi_cnt;
    int start_f1;
    logic [31:0] exp_stall;
`ifdef FEATURE_LOADER_PERF_CNT_EN
    exp_stall = 32'd20;
`else
    exp_stall = 32'd0;
`endif
    repeat (3) @(posedge system_clk);
    #1 rst = 1'b0;
    @(negedge system_clk);
    check("rst_busy", busy, 0);
    check("rst_finish", load_finish, 0);
    check("rst_req_valid", mem_rd_req_valid, 0);
    check("rst_data_ready", mem_rd_data_ready, 0);
    check("rst_f1_valid", feature_buffer_1_valid, 0);
    check("rst_stall", stall_cycles, 0);

    // Single patch 4x4: one burst of 4 words.
    push_req(32'h1000, 7'd4);
    push_words(32'h1000, 4, 1);
    exp_fin.push_back(1'b1);
    start(10'd4, 10'd4, 1'b0, 32'h1000, 32'h5000);
    wait_done("single", 200);

    // Double patch 10x10 with memory gaps, request backpressure and stray beats.
    req_gap = 1; mem_gap = 1; junk_en = 1;
    push_req(32'h0, 7'd16);
    push_req(32'h8000, 7'd16);
    push_req(32'h400, 7'd9);
    push_req(32'h8400, 7'd9);
    push_words(32'h0, 25, 1);
    push_words(32'h8000, 25, 2);
    exp_fin.push_back(1'b1);
    start(10'd10, 10'd10, 1'b1, 32'h0, 32'h8000);
    wait_done("double", 2000);
    req_gap = 0; mem_gap = 0; junk_en = 0;

    // Buffer 1 not ready for 20 REQ cycles.
    feature_buffer_1_ready = 1'b0;
    push_req(32'h2000, 7'd4);
    push_words(32'h2000, 4, 1);
    exp_fin.push_back(1'b1);
    start(10'd4, 10'd4, 1'b0, 32'h2000, 32'h0);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge system_clk);
      if (mem_rd_req_valid) hi_cnt++;
      @(posedge system_clk);
    end
    #1 feature_buffer_1_ready = 1'b1;
    check("stall_req_low", hi_cnt, 0);
    @(negedge system_clk);
    check("stall_req_before_edge", mem_rd_req_valid, 0);
    @(negedge system_clk);
    check("stall_req_after_edge", mem_rd_req_valid, 1);
    wait_done("stall", 200);
    check("stall_cycles", stall_cycles, exp_stall);

    // Empty map: finish two cycles after load_begin, no request.
    exp_fin.push_back(1'b0);
    start(10'd0, 10'd7, 1'b0, 32'h3000, 32'h0);
    @(negedge system_clk);
    check("zero_finish_early", load_finish, 0);
    check("zero_busy", busy, 1);
    @(negedge system_clk);
    check("zero_finish", load_finish, 1);
    check("zero_busy_drop", busy, 0);
    @(negedge system_clk);
    check("zero_finish_pulse", load_finish, 0);
    wait_done("zero", 20);

    // Reset during the fifth beat of a 16-word burst, then restart.
    push_req(32'h3000, 7'd16);
    push_words(32'h3000, 16, 1);
    exp_fin.push_back(1'b1);
    start_f1 = n_f1;
    start(10'd8, 10'd8, 1'b0, 32'h3000, 32'h0);
    hi_cnt = 0;
    while (n_f1 < start_f1 + 5 && hi_cnt < 200) begin
      @(negedge system_clk);
      hi_cnt++;
    end
    check("rst_mid_reached", hi_cnt < 200, 1);
    @(posedge system_clk); #1;
    rst = 1'b1;
    exp_req.delete(); exp_f1.delete(); exp_f2.delete(); exp_fin.delete();
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data_ready", mem_rd_data_ready, 0);
    check("rst_mid_f1_valid", feature_buffer_1_valid, 0);
    check("rst_mid_addr", mem_rd_addr, 0);
    check_data("rst_mid_data", feature_data, '0);
    @(negedge system_clk);
    check("rst_mid_req_valid", mem_rd_req_valid, 0);
    @(posedge system_clk); #1;
    rst = 1'b0;
    push_req(32'h3000, 7'd16);
    push_words(32'h3000, 16, 1);
    exp_fin.push_back(1'b1);
    start(10'd8, 10'd8, 1'b0, 32'h3000, 32'h0);
    wait_done("restart", 300);

    // load_begin pulsed mid-transfer with another configuration is ignored.
    push_req(32'h4000, 7'd16);
    push_req(32'h4400, 7'd16);
    push_req(32'h4800, 7'd4);
    push_words(32'h4000, 36, 1);
    exp_fin.push_back(1'b1);
    start(10'd12, 10'd12, 1'b0, 32'h4000, 32'h0);
    repeat (10) @(posedge system_clk);
    #1;
    row_size = 10'd2; col_size = 10'd2; feature_double_patch = 1'b1;
    base_addr_1 = 32'h9000; load_begin = 1'b1;
    @(posedge system_clk); #1;
    load_begin = 1'b0;
    wait_done("ignore_begin", 500);

    repeat (3) @(negedge system_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/feature_loader.md
Name: feature_loader

Overview:
- Producer side of the feature-buffer write interface.
- Fetches a feature map from external memory in bursts and pushes 4-pixel×8-channel words to the conv feature buffer.
- Words go to patch 1 only (8 channels) or alternate patch 1 / patch 2 (16 channels).
- Sits between the memory read port and the feature buffer; started by the layer controller alongside the buffer's calculate_begin.

Parameters:
- FEATURE_WIDTH, `FEATURE_WIDTH, bits per feature element.
- MEM_DATA_WIDTH, `MEM_DATA_WIDTH, memory word width; one word = 4 pixels × 8 channels.
- ADDR_WIDTH, 32, memory byte-address width.
- BURST_LEN, 16, maximum words per read burst; power of two, 1..64.

Ports:
- system_clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- load_begin  in  1  one-cycle start pulse; ignored unless IDLE
- load_finish  out  1  one-cycle pulse when the whole map has been delivered
- busy  out  1  high in any state except IDLE
- row_size  in  10  map rows; sampled at load_begin
- col_size  in  10  map columns; sampled at load_begin
- feature_double_patch  in  1  1 = patch 1 + patch 2; sampled at load_begin
- base_addr_1  in  ADDR_WIDTH  patch 1 byte base address; sampled at load_begin
- base_addr_2  in  ADDR_WIDTH  patch 2 byte base address; sampled at load_begin
- mem_rd_req_valid  out  1  burst request valid
- mem_rd_req_ready  in  1  burst request accepted
- mem_rd_addr  out  ADDR_WIDTH  burst start byte address
- mem_rd_len  out  7  burst length in words, 1..BURST_LEN
- mem_rd_data  in  MEM_DATA_WIDTH  return data
- mem_rd_data_valid  in  1  return beat valid
- mem_rd_data_ready  out  1  loader accepts return beat
- feature_data  out  MEM_DATA_WIDTH  word to feature buffer
- feature_buffer_1_valid  out  1  write strobe, patch 1 buffer
- feature_buffer_2_valid  out  1  write strobe, patch 2 buffer
- feature_buffer_1_ready  in  1  patch 1 buffer not at programmed-full level
- feature_buffer_2_ready  in  1  patch 2 buffer not at programmed-full level
- stall_cycles  out  32  performance counter; see Optional Feature

Behaviour:
- Reset values: all outputs 0; FSM IDLE; all counters and sampled configuration 0.
- Word count per patch: total_words = (row_size*col_size + 3) >> 2, computed with a 20-bit product and an 18-bit result. A partial last word is fetched whole; the buffer ignores the unused pixels.
- Configuration is registered at load_begin. Each patch keeps its own address pointer (init base_addr_n) and remaining-word counter (init total_words).
- State IDLE:
  - load_begin with total_words == 0 -> FINISH.
  - load_begin otherwise -> REQ, with cur_patch = 1.
- State REQ:
  - len = min(BURST_LEN, remaining[cur_patch]).
  - mem_rd_req_valid is asserted only while the target buffer's ready is 1.
  - Once asserted, valid, addr and len are held stable until mem_rd_req_ready. If the buffer's ready falls while valid is high, the request stays up.
  - On handshake: addr += len*(MEM_DATA_WIDTH/8); remaining -= len; beat_cnt = len; -> DATA.
- State DATA:
  - mem_rd_data_ready = 1.
  - Each accepted beat: feature_data <= mem_rd_data, and feature_buffer_<cur_patch>_valid <= 1 for one cycle, so output latency is 1 cycle. The other patch's valid stays 0.
  - No backpressure is applied mid-burst. The buffer's programmed-full slack is guaranteed ≥ BURST_LEN.
  - On the last beat:
    - Single patch: -> REQ if remaining[1] > 0, else -> FINISH.
    - Double patch: if cur_patch == 1, cur_patch = 2 and -> REQ. If cur_patch == 2, cur_patch = 1; -> REQ if remaining[1] > 0, else -> FINISH.
  - Both patches have equal word counts, so bursts strictly alternate p1, p2, p1, p2, ...
- State FINISH: load_finish = 1 for one cycle (the cycle after the last feature valid) -> IDLE.
- Valid strobes and feature_data: feature_data holds its last value when valid is 0. Both feature_buffer valids are never high together.
- mem_rd_data_valid outside DATA: the beat is dropped and mem_rd_data_ready is 0.
- load_begin while busy: ignored. Configuration is unchanged.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Any outstanding memory burst is the memory controller's responsibility to flush.

Optional Feature:
- Macro: FEATURE_LOADER_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each cycle the FSM is in REQ and no request handshake occurs (buffer not ready or mem_rd_req_ready low).
  - It clears on load_begin accepted in IDLE and on rst, and saturates at 32'hFFFFFFFF.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesized.

Test Plan:
- Single patch, row=4, col=4, base_addr_1=0x1000, memory always ready -> one request addr=0x1000, len=4 -> four feature_buffer_1_valid pulses, each 1 cycle after its mem beat -> load_finish one cycle after the last -> feature_buffer_2_valid never high.
- Double patch, row=10, col=10 (25 words), base_addr_1=0x0, base_addr_2=0x8000, MEM_DATA_WIDTH=512 -> requests in order (0x0,16), (0x8000,16), (0x400,9), (0x8400,9) -> 25 valids per patch.
- feature_buffer_1_ready=0 for 20 cycles in REQ -> mem_rd_req_valid stays 0 -> with perf macro, stall_cycles=20 -> request issues the cycle after ready rises.
- row=0, col=7 -> no memory request -> load_finish two cycles after load_begin -> busy drops.
- rst asserted during DATA beat 5 of 16 -> all outputs 0 next edge -> new load_begin restarts from base_addr_1 with len=16.
- load_begin pulsed again mid-transfer with different row_size -> ignored -> original request sequence and word counts unchanged.
